// File: rtl/pea_enable.sv
// pea_enable: decides whether the PEA may fire in its current mode.
// The block only observes FIFO occupancy/free-space counts and the head word
// of the command FIFO; it never pops, pushes or alters any FIFO.
// enable is registered: it reflects the inputs sampled on the previous edge.
module pea_enable #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  localparam int W          = $clog2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         command_pop,
  input  logic [W-1:0]         data_pop,
  input  logic [W-1:0]         result_free_space,
  input  logic [W-1:0]         status_free_space,
  input  logic [2:0]           mode,
  input  logic [word_size-1:0] command_in,
  output logic                 enable
);

  // PEA mode encoding; values 6 and 7 are unused and never fire.
  typedef enum logic [2:0] {
    MODE_GET_COMMAND = 3'd0,
    MODE_STP         = 3'd1,
    MODE_EVP         = 3'd2,
    MODE_EVB         = 3'd3,
    MODE_OUTPUT      = 3'd4,
    MODE_RST         = 3'd5
  } mode_e;

  // Comparison width: wide enough for a W-bit count, the 5-bit batch count
  // and N_reg+1 (up to 16) with one spare bit so nothing ever wraps.
  localparam int BASE_W = (W > 5) ? W : 5;
  localparam int EW     = BASE_W + 1;

  // Decoded fields of the command FIFO head word.
  logic [2:0] cmd_opcode;
  logic [3:0] cmd_n;
  logic [4:0] cmd_b;

  // Latched polynomial degree and batch count.
  logic [3:0] n_reg;
  logic [4:0] b_reg;

  // Zero-extended counts and thresholds for overflow-free unsigned compares.
  logic [EW-1:0] command_ext;
  logic [EW-1:0] data_ext;
  logic [EW-1:0] result_ext;
  logic [EW-1:0] status_ext;
  logic [EW-1:0] n_plus_one;
  logic [EW-1:0] b_ext;

  // Per-term condition flags.
  logic have_command;
  logic have_data;
  logic have_result_slot;
  logic have_status_slot;
  logic stp_ready;
  logic evb_data_ready;
  logic evb_result_ready;

  // Combinational firing condition for the current mode.
  logic cond;

  // Opcode and reserved bits are carried by the command word but are not
  // needed to decide enable; fold them into a sink so they are visibly unused.
  logic unused_cmd_bits;

  // Split the command head word into its fields (peek only).
  always_comb begin
    cmd_opcode = command_in[2:0];
    cmd_n      = command_in[6:3];
    cmd_b      = command_in[11:7];
  end

  assign unused_cmd_bits = ^{cmd_opcode, command_in[word_size-1:12]};

  // Latch N and b whenever a command is available while fetching commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg <= 4'd0;
      b_reg <= 5'd0;
    end else if ((mode == MODE_GET_COMMAND) && have_command) begin
      n_reg <= cmd_n;
      b_reg <= cmd_b;
    end
  end

  // Widen every count and threshold to a common width before comparing.
  always_comb begin
    command_ext = EW'(command_pop);
    data_ext    = EW'(data_pop);
    result_ext  = EW'(result_free_space);
    status_ext  = EW'(status_free_space);
    n_plus_one  = EW'(n_reg) + EW'(1);
    b_ext       = EW'(b_reg);
  end

  // Evaluate the individual threshold terms shared between modes.
  always_comb begin
    have_command     = (command_ext != '0);
    have_data        = (data_ext != '0);
    have_result_slot = (result_ext != '0);
    have_status_slot = (status_ext != '0);
    stp_ready        = (data_ext >= n_plus_one);
    evb_data_ready   = (data_ext >= b_ext);
    evb_result_ready = (result_ext >= b_ext);
  end

  // Select the firing condition for the current mode.
  always_comb begin
    cond = 1'b0;
    case (mode)
      MODE_GET_COMMAND: cond = have_command;
      MODE_STP:         cond = stp_ready;
      MODE_EVP:         cond = have_data && have_result_slot && have_status_slot;
      MODE_EVB:         cond = evb_data_ready && evb_result_ready && have_status_slot;
      MODE_OUTPUT:      cond = have_result_slot && have_status_slot;
      MODE_RST:         cond = 1'b1;
      default:          cond = 1'b0;
    endcase
  end

  // Register the condition; reset forces enable low immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable <= 1'b0;
    end else begin
      enable <= cond;
    end
  end

endmodule

// File: tb/tb_pea_enable.sv
// Directed testbench for pea_enable: one task per scenario, inline checks,
// hand-computed expected values, single summary line at the end.
module tb_pea_enable;

  localparam int WORD = 16;
  localparam int BUF  = 1024;
  localparam int W    = 10;

  logic            clk;
  logic            rst;
  logic [W-1:0]    command_pop;
  logic [W-1:0]    data_pop;
  logic [W-1:0]    result_free_space;
  logic [W-1:0]    status_free_space;
  logic [2:0]      mode;
  logic [WORD-1:0] command_in;
  logic            enable;

  int n_checks = 0;
  int n_errors = 0;

  pea_enable #(
    .word_size   (WORD),
    .buffer_size (BUF)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .command_pop       (command_pop),
    .data_pop          (data_pop),
    .result_free_space (result_free_space),
    .status_free_space (status_free_space),
    .mode              (mode),
    .command_in        (command_in),
    .enable            (enable)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so sampling is off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Build a command word from N and b (opcode and reserved bits set to noise).
  function automatic logic [WORD-1:0] cmd(input int n, input int b);
    logic [WORD-1:0] w;
    w        = '0;
    w[2:0]   = 3'd6;
    w[6:3]   = n[3:0];
    w[11:7]  = b[4:0];
    w[15:12] = 4'hA;
    return w;
  endfunction

  // Latch a command through GET_COMMAND with one word available.
  task automatic load_cmd(input int n, input int b);
    mode        = 3'd0;
    command_in  = cmd(n, b);
    command_pop = 10'd1;
    step();
    command_pop = 10'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mode = 3'd0; command_pop = '0; data_pop = '0;
    result_free_space = '0; status_free_space = '0; command_in = '0;
    #3;
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_low: enable=%b expected 0", enable);
    end
    step(); step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_held: enable=%b expected 0", enable);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL get_cmd_empty: enable=%b expected 0", enable);
    end
    command_pop = 10'd1;
    #1;
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL get_cmd_latency: enable=%b expected 0 before edge", enable);
    end
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL get_cmd_ready: enable=%b expected 1", enable);
    end
    command_pop = 10'd0;
  endtask

  task automatic test_stp();
    load_cmd(3, 0);
    mode = 3'd1; data_pop = 10'd3;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL stp_n3_data3: enable=%b expected 0", enable);
    end
    data_pop = 10'd4;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL stp_n3_data4: enable=%b expected 1", enable);
    end
    data_pop = 10'd3;
    #1;
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL stp_hold_until_edge: enable=%b expected 1", enable);
    end
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL stp_drop: enable=%b expected 0", enable);
    end
    // Maximum degree: N=15 needs 16 data words.
    load_cmd(15, 0);
    mode = 3'd1; data_pop = 10'd15;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL stp_n15_data15: enable=%b expected 0", enable);
    end
    data_pop = 10'd16;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL stp_n15_data16: enable=%b expected 1", enable);
    end
    data_pop = 10'd1023;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL stp_n15_data1023: enable=%b expected 1", enable);
    end
    data_pop = '0;
  endtask

  task automatic test_evb();
    load_cmd(0, 5);
    mode = 3'd3; data_pop = 10'd5; status_free_space = 10'd1;
    result_free_space = 10'd4;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evb_result4: enable=%b expected 0", enable);
    end
    result_free_space = 10'd5;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL evb_result5: enable=%b expected 1", enable);
    end
    data_pop = 10'd4;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evb_data4: enable=%b expected 0", enable);
    end
    data_pop = 10'd5; status_free_space = 10'd0;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evb_status0: enable=%b expected 0", enable);
    end
    // b=0: only status space matters.
    load_cmd(9, 0);
    mode = 3'd3; data_pop = '0; result_free_space = '0; status_free_space = 10'd1;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL evb_b0_status1: enable=%b expected 1", enable);
    end
    status_free_space = 10'd0;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evb_b0_status0: enable=%b expected 0", enable);
    end
  endtask

  task automatic test_evp_output();
    mode = 3'd2; data_pop = 10'd1; result_free_space = 10'd1; status_free_space = 10'd0;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evp_status0: enable=%b expected 0", enable);
    end
    status_free_space = 10'd1;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL evp_all1: enable=%b expected 1", enable);
    end
    data_pop = 10'd0;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evp_data0: enable=%b expected 0", enable);
    end
    data_pop = 10'd1; result_free_space = 10'd0;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL evp_result0: enable=%b expected 0", enable);
    end
    mode = 3'd4; data_pop = 10'd0; result_free_space = 10'd1; status_free_space = 10'd0;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL out_status0: enable=%b expected 0", enable);
    end
    status_free_space = 10'd1;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL out_status1: enable=%b expected 1", enable);
    end
    result_free_space = 10'd0; status_free_space = 10'd1023;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL out_result0: enable=%b expected 0", enable);
    end
    result_free_space = 10'd1023;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL out_full_counts: enable=%b expected 1", enable);
    end
  endtask

  task automatic test_rst_modes();
    mode = 3'd5; command_pop = '0; data_pop = '0;
    result_free_space = '0; status_free_space = '0;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL mode_rst: enable=%b expected 1", enable);
    end
    mode = 3'd6; command_pop = 10'd5; data_pop = 10'd5;
    result_free_space = 10'd5; status_free_space = 10'd5;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL mode6: enable=%b expected 0", enable);
    end
    mode = 3'd5;
    step();
    mode = 3'd7;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL mode7: enable=%b expected 0", enable);
    end
    command_pop = '0; data_pop = '0; result_free_space = '0; status_free_space = '0;
  endtask

  task automatic test_async_reset();
    load_cmd(7, 9);
    mode = 3'd5;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL async_pre: enable=%b expected 1", enable);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL async_drop: enable=%b expected 0 before next edge", enable);
    end
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL async_held: enable=%b expected 0", enable);
    end
    // After reset N_reg is 0: STP needs just one data word.
    mode = 3'd1; data_pop = 10'd0;
    rst = 1'b1;
    step();
    n_checks++;
    if (enable !== 1'b0) begin
      n_errors++;
      $display("FAIL post_rst_stp0: enable=%b expected 0", enable);
    end
    data_pop = 10'd1;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL post_rst_stp1: enable=%b expected 1", enable);
    end
    // b_reg also cleared: EVB needs only status space.
    mode = 3'd3; data_pop = '0; result_free_space = '0; status_free_space = 10'd1;
    step();
    n_checks++;
    if (enable !== 1'b1) begin
      n_errors++;
      $display("FAIL post_rst_evb: enable=%b expected 1", enable);
    end
  endtask

  initial begin
    test_reset();
    test_stp();
    test_evb();
    test_evp_output();
    test_rst_modes();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
